rot_arbiter: RTL and testbench

Shares one 4-bit rotate/invert datapath among NREQ requesters. Each requester presents a mode and a 4-bit operand. A round-robin arbiter grants one requester at a time. The block sequences the operation through a small FSM and returns the result over a valid/ready response port tagged with the winner's index. It sits between client logic and the shared rotate/invert unit, which is instantiated inside as a combinational sub-module.

---
 rtl/rot_pkg.sv | 15 +
 rtl/rot_inv_unit.sv | 21 ++
 rtl/rot_arbiter.sv | 128 ++++++++++++
 tb/tb_rot_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the rotate/invert arbiter: datapath mode codes and FSM states.
package rot_pkg;

  localparam logic [1:0] MODE_INV  = 2'b00;
  localparam logic [1:0] MODE_ROL1 = 2'b01;
  localparam logic [1:0] MODE_ROL2 = 2'b10;
  localparam logic [1:0] MODE_ROL3 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rot_inv_unit.sv
// Shared combinational rotate/invert datapath; the single definition of the operation.
module rot_inv_unit
  import rot_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] a,
  output logic [3:0] y
);

  always_comb begin
    y = ~a;
    case (mode)
      MODE_INV:  y = ~a;
      MODE_ROL1: y = {a[2:0], a[3]};
      MODE_ROL2: y = {a[1:0], a[3:2]};
      MODE_ROL3: y = {a[0], a[3:1]};
      default:   y = ~a;
    endcase
  end

endmodule

// File: rtl/rot_arbiter.sv
// Round-robin arbiter sharing one rotate/invert unit among NREQ requesters,
// with a registered grant and a valid/ready response tagged by the winner.
module rot_arbiter
  import rot_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   req_mode,
  input  logic [4*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     gnt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_data,
  output logic [IDW-1:0]      out_id,
  output logic                busy
);

  state_t            r_state;
  state_t            w_nextState;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_opId;
  logic [1:0]        r_opMode;
  logic [3:0]        r_opData;
  logic [NREQ-1:0]   r_gnt;
  logic              r_outValid;
  logic [3:0]        r_outData;
  logic [IDW-1:0]    r_outId;

  logic [NREQ-1:0]   w_reqRot;
  logic              w_found;
  logic [IDW:0]      w_sum;
  logic [IDW-1:0]    w_winner;
  logic [IDW-1:0]    w_ptrNext;
  logic [1:0]        w_mode;
  logic [3:0]        w_data;
  logic [3:0]        w_y;

  // Rotating req so that the requester at ptr lands in bit 0 turns round-robin into a plain priority scan.
  assign w_reqRot = NREQ'({req, req} >> r_ptr);

  always_comb begin
    w_found  = 1'b0;
    w_sum    = '0;
    w_winner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && w_reqRot[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (IDW+1)'(i);
        if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
        w_winner = w_sum[IDW-1:0];
      end
    end
  end

  assign w_mode    = 2'(req_mode >> {w_winner, 1'b0});
  assign w_data    = 4'(req_data >> {w_winner, 2'b00});
  assign w_ptrNext = (r_opId == IDW'(NREQ - 1)) ? '0 : r_opId + 1'b1;

  rot_inv_unit u_unit (
    .mode (r_opMode),
    .a    (r_opData),
    .y    (w_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (|req) w_nextState = EXEC;
      EXEC:    w_nextState = RESP;
      RESP:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operands are captured at the grant edge so later input changes cannot disturb the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr      <= '0;
      r_opId     <= '0;
      r_opMode   <= '0;
      r_opData   <= '0;
      r_gnt      <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outId    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_opId   <= w_winner;
            r_opMode <= w_mode;
            r_opData <= w_data;
            r_gnt    <= NREQ'(1) << w_winner;
          end
        end
        EXEC: begin
          r_outData  <= w_y;
          r_outId    <= r_opId;
          r_outValid <= 1'b1;
          r_gnt      <= '0;
        end
        RESP: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_ptr      <= w_ptrNext;
          end
        end
        default: r_gnt <= '0;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_id    = r_outId;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rot_arbiter.sv
// Directed self-checking bench for rot_arbiter with NREQ=4.
module tb_rot_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_mode;
  logic [4*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_data;
  logic [IDW-1:0]    out_id;
  logic              busy;

  int total = 0;
  int bad   = 0;

  rot_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [7:0] m,
                               input logic [15:0] d, input logic rdy);
    req       = r;
    req_mode  = m;
    req_data  = d;
    out_ready = rdy;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] modeVec [3] = '{2'b01, 2'b10, 2'b11};
  logic [3:0] dataVec [3] = '{4'b1001, 4'b1000, 4'b0001};
  logic [3:0] expVec  [3] = '{4'b0011, 4'b0010, 4'b1000};
  logic [3:0] rrGnt   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rrId    [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] rrData  [5] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hF};

  initial begin
    reset = 1'b1;
    applyStimulus(4'b0000, 8'h00, 16'h0000, 1'b1);
    #3;
    checkOutput("rst_gnt",   32'(gnt), 32'h0);
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_data",  32'(out_data), 32'h0);
    checkOutput("rst_id",    32'(out_id), 32'h0);
    checkOutput("rst_busy",  32'(busy), 32'h0);
    #10 reset = 1'b0;
    tick();

    // Single requester 2, invert 1010.
    applyStimulus(4'b0100, 8'h00, 16'h0A00, 1'b1);
    tick();
    checkOutput("r2_gnt",  32'(gnt), 32'h4);
    checkOutput("r2_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    checkOutput("r2_gnt_clr", 32'(gnt), 32'h0);
    checkOutput("r2_valid",   32'(out_valid), 32'h1);
    checkOutput("r2_data",    32'(out_data), 32'h5);
    checkOutput("r2_id",      32'(out_id), 32'h2);
    tick();
    checkOutput("r2_done_valid", 32'(out_valid), 32'h0);
    checkOutput("r2_done_busy",  32'(busy), 32'h0);

    // Rotate modes on requester 0.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0001, {6'b0, modeVec[k]}, {12'h000, dataVec[k]}, 1'b1);
      tick();
      checkOutput("mode_gnt", 32'(gnt), 32'h1);
      req = 4'b0000;
      tick();
      checkOutput("mode_data", 32'(out_data), 32'(expVec[k]));
      checkOutput("mode_id",   32'(out_id), 32'h0);
      tick();
      checkOutput("mode_idle", 32'(busy), 32'h0);
    end

    // Requester 1 rol1 0110, operands change in the grant cycle; then backpressure.
    applyStimulus(4'b0010, 8'b0000_0100, 16'h0060, 1'b0);
    tick();
    checkOutput("chg_gnt", 32'(gnt), 32'h2);
    applyStimulus(4'b0000, 8'h00, 16'h00F0, 1'b0);
    tick();
    checkOutput("chg_data", 32'(out_data), 32'hC);
    checkOutput("chg_id",   32'(out_id), 32'h1);
    applyStimulus(4'b1111, 8'h00, 16'h3210, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("bp_valid", 32'(out_valid), 32'h1);
      checkOutput("bp_data",  32'(out_data), 32'hC);
      checkOutput("bp_id",    32'(out_id), 32'h1);
      checkOutput("bp_gnt",   32'(gnt), 32'h0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bp_done_valid", 32'(out_valid), 32'h0);
    checkOutput("bp_done_gnt",   32'(gnt), 32'h0);
    checkOutput("bp_done_busy",  32'(busy), 32'h0);
    out_ready = 1'b0;
    tick();
    checkOutput("bp_next_gnt", 32'(gnt), 32'h4);
    tick();
    checkOutput("pre_rst_valid", 32'(out_valid), 32'h1);
    checkOutput("pre_rst_data",  32'(out_data), 32'hD);

    // Asynchronous reset while the response is pending.
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'h0);
    checkOutput("mid_rst_gnt",   32'(gnt), 32'h0);
    checkOutput("mid_rst_busy",  32'(busy), 32'h0);
    checkOutput("mid_rst_data",  32'(out_data), 32'h0);
    checkOutput("mid_rst_id",    32'(out_id), 32'h0);
    #1 reset = 1'b0;
    out_ready = 1'b1;

    // All requesters held high: strict rotation starting from 0.
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("rr_gnt", 32'(gnt), 32'(rrGnt[k]));
      tick();
      checkOutput("rr_id",   32'(out_id), 32'(rrId[k]));
      checkOutput("rr_data", 32'(out_data), 32'(rrData[k]));
      tick();
      checkOutput("rr_gap_gnt", 32'(gnt), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
